// File: rtl/kbd_num_fifo.sv
// Keyboard number entry: PS/2 break codes edit a multi-digit accumulator, Enter commits it
// into a FIFO, and the CPU pops one value per request. Define KBD_NUM_FIFO_DEC_EN for decimal entry.
module kbd_num_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int MAX_DIGITS = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int LW = $clog2(MAX_DIGITS + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           code,
    input  logic                  control,
    output logic                  status,
    output logic [DATA_WIDTH-1:0] num,
    output logic                  valid,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] edit_value,
    output logic [LW-1:0]         edit_len
);

    logic [15:0]           code_q, code_d;
    logic                  control_q, control_d;
    logic                  req_q, req_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] num_q, num_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [LW-1:0]         len_q, len_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic                  key_evt, is_digit, is_enter, is_bksp, is_esc;
    logic [3:0]            digit;
    logic [DATA_WIDTH-1:0] acc_push, acc_pop;
    logic                  push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        key_evt  = (code != code_q) && (code[15:8] == 8'hF0);
        is_digit = 1'b1;
        digit    = 4'h0;
        is_enter = (code[7:0] == 8'h5A);
        is_bksp  = (code[7:0] == 8'h66);
        is_esc   = (code[7:0] == 8'h76);
        case (code[7:0])
            8'h45: digit = 4'h0;
            8'h16: digit = 4'h1;
            8'h1E: digit = 4'h2;
            8'h26: digit = 4'h3;
            8'h25: digit = 4'h4;
            8'h2E: digit = 4'h5;
            8'h36: digit = 4'h6;
            8'h3D: digit = 4'h7;
            8'h3E: digit = 4'h8;
            8'h46: digit = 4'h9;
            8'h1C: digit = 4'hA;
            8'h32: digit = 4'hB;
            8'h21: digit = 4'hC;
            8'h23: digit = 4'hD;
            8'h24: digit = 4'hE;
            8'h2B: digit = 4'hF;
            default: is_digit = 1'b0;
        endcase
`ifdef KBD_NUM_FIFO_DEC_EN
        if (digit > 4'd9) is_digit = 1'b0;
        acc_push = acc_q * DATA_WIDTH'(10) + DATA_WIDTH'(digit);
        acc_pop  = acc_q / DATA_WIDTH'(10);
`else
        acc_push = {acc_q[DATA_WIDTH-5:0], digit};
        acc_pop  = acc_q >> 4;
`endif
    end

    // CPU handshake: a rising edge on control raises a request (status); the request is served
    // by a one-cycle valid pulse with num, or withdrawn when control falls. Held control pops once.
    always_comb begin
        code_d     = code;
        control_d  = control;
        req_d      = req_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        num_d      = num_q;
        acc_d      = acc_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        push       = 1'b0;
        pop        = req_q && (count_q != '0);

        if (key_evt) begin
            if (is_digit) begin
                if (len_q < LW'(MAX_DIGITS)) begin
                    acc_d = acc_push;
                    len_d = len_q + LW'(1);
                end
            end else if (is_enter) begin
                if (len_q != '0) begin
                    // Full check uses the pre-pop count, so a simultaneous pop does not make room.
                    if (count_q < CW'(DEPTH)) push = 1'b1;
                    else                      overflow_d = 1'b1;
                    acc_d = '0;
                    len_d = '0;
                end
            end else if (is_bksp) begin
                if (len_q != '0) begin
                    acc_d = acc_pop;
                    len_d = len_q - LW'(1);
                end
            end else if (is_esc) begin
                acc_d = '0;
                len_d = '0;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = acc_q;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            num_d    = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (pop || (!control && control_q)) req_d = 1'b0;
        if (control && !control_q)          req_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q     <= '0;
            control_q  <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            num_q      <= '0;
            acc_q      <= '0;
            len_q      <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            code_q     <= code_d;
            control_q  <= control_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            num_q      <= num_d;
            acc_q      <= acc_d;
            len_q      <= len_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign status     = req_q;
    assign num        = num_q;
    assign valid      = valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign edit_value = acc_q;
    assign edit_len   = len_q;

endmodule
